// File: rtl/wb_stage_ctrl.sv
// Writeback stage controller for the pipelined MIPS core.
// Holds the M/W pipeline register. Decodes the W instruction into a writeback
// class. Extends load data, selects the register-file write address and data,
// and counts the instructions that leave W.
module wb_stage_ctrl #(
  parameter int unsigned LINK_OFF = 8,
  parameter bit          HILO_EN  = 1'b1,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [31:0]      instr_M,
  input  logic [31:0]      pc_M,
  input  logic [31:0]      alu_M,
  input  logic [31:0]      mem_M,
  input  logic [1:0]       alo_M,
  input  logic [31:0]      hi_M,
  input  logic [31:0]      lo_M,
  output logic             valid_W,
  output logic [31:0]      instr_W,
  output logic [31:0]      pc_W,
  output logic             we_W,
  output logic [4:0]       waddr_W,
  output logic [31:0]      wdata_W,
  output logic             is_load_W,
  output logic [CNT_W-1:0] retired
);

  // Writeback classes: which register is written, and where the data comes from.
  typedef enum logic [2:0] {
    WB_NONE,
    WB_ALU_RD,
    WB_ALU_RT,
    WB_LOAD_RT,
    WB_LINK_RD,
    WB_LINK_RA,
    WB_HI_RD,
    WB_LO_RD
  } wb_class_t;

  // Primary opcodes that the decoder recognises.
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_SLTIU   = 6'b001011;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LH      = 6'b100001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_LHU     = 6'b100101;

  // SPECIAL function codes that produce a register write.
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // REGIMM rt codes for the linking branches.
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  localparam logic [31:0] LINK_INC = 32'(LINK_OFF);
  localparam logic [4:0]  REG_RA   = 5'd31;

  // M/W pipeline register contents.
  logic             valid_r;
  logic [31:0]      instr_r;
  logic [31:0]      pc_r;
  logic [31:0]      alu_r;
  logic [31:0]      mem_r;
  logic [1:0]       alo_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic [CNT_W-1:0] retired_r;

  // Decode fields and intermediate results.
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  wb_class_t   wb_class;
  logic        class_writes;
  logic        op_is_load;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] link_data;
  logic [4:0]  waddr_sel;
  logic [31:0] wdata_sel;
  logic        w_vacated;

  assign opcode    = instr_r[31:26];
  assign funct     = instr_r[5:0];
  assign rt        = instr_r[20:16];
  assign rd        = instr_r[15:11];
  assign link_data = pc_r + LINK_INC;

  // W is vacated whenever its contents are replaced, either by a bubble or by
  // the next instruction. This is what retires the held instruction exactly once.
  assign w_vacated = en | flush;

  // Pipeline register: flush wins over en, and en low holds everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      instr_r <= '0;
      pc_r    <= '0;
      alu_r   <= '0;
      mem_r   <= '0;
      alo_r   <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else if (flush) begin
      valid_r <= 1'b0;
      instr_r <= '0;
      pc_r    <= '0;
      alu_r   <= '0;
      mem_r   <= '0;
      alo_r   <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else if (en) begin
      valid_r <= 1'b1;
      instr_r <= instr_M;
      pc_r    <= pc_M;
      alu_r   <= alu_M;
      mem_r   <= mem_M;
      alo_r   <= alo_M;
      hi_r    <= hi_M;
      lo_r    <= lo_M;
    end
  end

  // Retired counter: one count each time a valid instruction leaves W. It wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_r <= '0;
    end else if (valid_r && w_vacated) begin
      retired_r <= retired_r + CNT_W'(1);
    end
  end

  // Classify the W instruction by destination register and data source.
  always_comb begin
    wb_class = WB_NONE;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU,
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV:
            wb_class = WB_ALU_RD;
          FN_JALR:
            wb_class = WB_LINK_RD;
          FN_MFHI:
            wb_class = HILO_EN ? WB_HI_RD : WB_NONE;
          FN_MFLO:
            wb_class = HILO_EN ? WB_LO_RD : WB_NONE;
          default:
            wb_class = WB_NONE;
        endcase
      end
      OP_REGIMM: begin
        if (rt == RT_BLTZAL || rt == RT_BGEZAL) begin
          wb_class = WB_LINK_RA;
        end
      end
      OP_JAL:
        wb_class = WB_LINK_RA;
      OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SLTI, OP_SLTIU:
        wb_class = WB_ALU_RT;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:
        wb_class = WB_LOAD_RT;
      default:
        wb_class = WB_NONE;
    endcase
  end

  // Flag the loads separately because the hazard unit needs this even for loads to $0.
  always_comb begin
    op_is_load = 1'b0;
    case (opcode)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: op_is_load = 1'b1;
      default:                             op_is_load = 1'b0;
    endcase
  end

  // Pick the addressed byte and halfword out of the raw memory word. Halfwords ignore alo[0].
  always_comb begin
    byte_sel = mem_r[7:0];
    case (alo_r)
      2'd0:    byte_sel = mem_r[7:0];
      2'd1:    byte_sel = mem_r[15:8];
      2'd2:    byte_sel = mem_r[23:16];
      2'd3:    byte_sel = mem_r[31:24];
      default: byte_sel = mem_r[7:0];
    endcase
    half_sel = alo_r[1] ? mem_r[31:16] : mem_r[15:0];
  end

  // Sign- or zero-extend the selected byte/halfword according to the load type.
  always_comb begin
    load_data = mem_r;
    case (opcode)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'd0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'd0, half_sel};
      default: load_data = mem_r;
    endcase
  end

  // Steer the write address and data from the writeback class. For no-write
  // classes, rd and alu are passed through.
  always_comb begin
    waddr_sel    = rd;
    wdata_sel    = alu_r;
    class_writes = 1'b1;
    case (wb_class)
      WB_ALU_RD: begin
        waddr_sel = rd;
        wdata_sel = alu_r;
      end
      WB_ALU_RT: begin
        waddr_sel = rt;
        wdata_sel = alu_r;
      end
      WB_LOAD_RT: begin
        waddr_sel = rt;
        wdata_sel = load_data;
      end
      WB_LINK_RD: begin
        waddr_sel = rd;
        wdata_sel = link_data;
      end
      WB_LINK_RA: begin
        waddr_sel = REG_RA;
        wdata_sel = link_data;
      end
      WB_HI_RD: begin
        waddr_sel = rd;
        wdata_sel = hi_r;
      end
      WB_LO_RD: begin
        waddr_sel = rd;
        wdata_sel = lo_r;
      end
      default: begin
        waddr_sel    = rd;
        wdata_sel    = alu_r;
        class_writes = 1'b0;
      end
    endcase
  end

  assign valid_W   = valid_r;
  assign instr_W   = instr_r;
  assign pc_W      = pc_r;
  assign waddr_W   = waddr_sel;
  assign wdata_W   = wdata_sel;
  assign we_W      = valid_r & class_writes & (waddr_sel != 5'd0);
  assign is_load_W = valid_r & op_is_load;
  assign retired   = retired_r;

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// Self-checking bench for wb_stage_ctrl. It runs two instances: one with
// the default parameters, and one with HILO_EN=0 and CNT_W=4. Expected
// values come from a behavioural model of the W stage and from
// directed constants.
module tb_wb_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        flush;
  logic [31:0] instr_M, pc_M, alu_M, mem_M, hi_M, lo_M;
  logic [1:0]  alo_M;

  logic        a_valid, a_we, a_is_load;
  logic [31:0] a_instr, a_pc, a_wdata;
  logic [4:0]  a_waddr;
  logic [31:0] a_retired;

  logic        b_valid, b_we, b_is_load;
  logic [31:0] b_instr, b_pc, b_wdata;
  logic [4:0]  b_waddr;
  logic [3:0]  b_retired;

  int checks = 0;
  int errors = 0;

  // Behavioural picture of what W should hold.
  typedef struct {
    bit          valid;
    logic [31:0] instr, pc, alu, mem, hi, lo;
    logic [1:0]  alo;
  } w_t;

  w_t          model;
  int unsigned model_retired;

  localparam logic [5:0] R_FUNCTS [20] = '{
    6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
    6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b000011, 6'b000100,
    6'b000110, 6'b000111, 6'b001001, 6'b010000, 6'b010010, 6'b001000,
    6'b011000, 6'b011010};
  localparam logic [5:0] OPS [16] = '{
    6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001111, 6'b001010,
    6'b001011, 6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
    6'b000011, 6'b101011, 6'b000100, 6'b000010};

  // 10 time-unit clock.
  always #5 clk = ~clk;

  wb_stage_ctrl #(.LINK_OFF(8), .HILO_EN(1'b1), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .instr_M(instr_M), .pc_M(pc_M), .alu_M(alu_M), .mem_M(mem_M),
    .alo_M(alo_M), .hi_M(hi_M), .lo_M(lo_M),
    .valid_W(a_valid), .instr_W(a_instr), .pc_W(a_pc), .we_W(a_we),
    .waddr_W(a_waddr), .wdata_W(a_wdata), .is_load_W(a_is_load),
    .retired(a_retired));

  wb_stage_ctrl #(.LINK_OFF(8), .HILO_EN(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .instr_M(instr_M), .pc_M(pc_M), .alu_M(alu_M), .mem_M(mem_M),
    .alo_M(alo_M), .hi_M(hi_M), .lo_M(lo_M),
    .valid_W(b_valid), .instr_W(b_instr), .pc_W(b_pc), .we_W(b_we),
    .waddr_W(b_waddr), .wdata_W(b_wdata), .is_load_W(b_is_load),
    .retired(b_retired));

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Reference writeback decision, worked out from the instruction tables
  // with plain arithmetic.
  function automatic void ref_wb(input w_t m, input bit hilo_en, output bit we,
                                 output logic [4:0] addr, output logic [31:0] data,
                                 output bit is_load);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] link;
    logic [31:0] b;
    logic [31:0] h;
    bit          writes;
    op     = m.instr[31:26];
    fn     = m.instr[5:0];
    rt     = m.instr[20:16];
    rd     = m.instr[15:11];
    link   = m.pc + 32'd8;
    writes = 1'b0;
    addr   = 5'd0;
    data   = 32'd0;
    is_load = 1'b0;
    b = (m.mem >> (8 * m.alo)) & 32'hFF;
    h = (m.mem >> (16 * (m.alo / 2))) & 32'hFFFF;
    if (op == 6'b000000) begin
      if (fn inside {6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                     6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b000011, 6'b000100,
                     6'b000110, 6'b000111}) begin
        writes = 1'b1; addr = rd; data = m.alu;
      end else if (fn == 6'b001001) begin
        writes = 1'b1; addr = rd; data = link;
      end else if (fn == 6'b010000 && hilo_en) begin
        writes = 1'b1; addr = rd; data = m.hi;
      end else if (fn == 6'b010010 && hilo_en) begin
        writes = 1'b1; addr = rd; data = m.lo;
      end
    end else if (op inside {6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001111,
                            6'b001010, 6'b001011}) begin
      writes = 1'b1; addr = rt; data = m.alu;
    end else if (op inside {6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101}) begin
      writes = 1'b1; addr = rt; is_load = 1'b1;
      case (op)
        6'b100000: data = (b >= 32'd128)   ? b - 32'd256   : b;
        6'b100100: data = b;
        6'b100001: data = (h >= 32'd32768) ? h - 32'd65536 : h;
        6'b100101: data = h;
        default:   data = m.mem;
      endcase
    end else if (op == 6'b000011) begin
      writes = 1'b1; addr = 5'd31; data = link;
    end else if (op == 6'b000001 && (rt == 5'd16 || rt == 5'd17)) begin
      writes = 1'b1; addr = 5'd31; data = link;
    end
    we      = m.valid && writes && (addr != 5'd0);
    is_load = m.valid && is_load;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    model.valid = 1'b0;
    model.instr = '0; model.pc = '0; model.alu = '0; model.mem = '0;
    model.hi = '0;    model.lo = '0; model.alo = '0;
  endtask

  // Drive the M inputs and advance the model, then step one clock and settle past the edge.
  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc,
                               input logic [31:0] alu, input logic [31:0] mem,
                               input logic [1:0] alo, input logic [31:0] hi,
                               input logic [31:0] lo, input bit e, input bit f);
    instr_M = ins; pc_M = pc; alu_M = alu; mem_M = mem;
    alo_M = alo;   hi_M = hi; lo_M = lo;   en = e; flush = f;
    if (f) begin
      if (model.valid) model_retired++;
      clearModel();
    end else if (e) begin
      if (model.valid) model_retired++;
      model.valid = 1'b1;
      model.instr = ins; model.pc = pc; model.alu = alu; model.mem = mem;
      model.alo = alo;   model.hi = hi; model.lo = lo;
    end
    @(posedge clk);
    #1;
  endtask

  // Compare both instances against the model. Address and data are checked only when a write is due.
  task automatic checkOutput();
    bit          we_a, we_b, ld_a, ld_b;
    logic [4:0]  ad_a, ad_b;
    logic [31:0] d_a, d_b;
    ref_wb(model, 1'b1, we_a, ad_a, d_a, ld_a);
    ref_wb(model, 1'b0, we_b, ad_b, d_b, ld_b);
    checkValue("a_valid", {31'd0, a_valid}, {31'd0, model.valid});
    checkValue("a_instr", a_instr, model.instr);
    checkValue("a_pc", a_pc, model.pc);
    checkValue("a_we", {31'd0, a_we}, {31'd0, we_a});
    checkValue("a_is_load", {31'd0, a_is_load}, {31'd0, ld_a});
    checkValue("a_retired", a_retired, model_retired);
    if (we_a) begin
      checkValue("a_waddr", {27'd0, a_waddr}, {27'd0, ad_a});
      checkValue("a_wdata", a_wdata, d_a);
    end
    checkValue("b_we", {31'd0, b_we}, {31'd0, we_b});
    checkValue("b_retired", {28'd0, b_retired}, model_retired % 16);
    if (we_b) begin
      checkValue("b_waddr", {27'd0, b_waddr}, {27'd0, ad_b});
      checkValue("b_wdata", b_wdata, d_b);
    end
  endtask

  // Random instruction drawn mostly from the interesting encodings.
  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0, 1: r = r_type(r[25:21], r[20:16], r[15:11], R_FUNCTS[$urandom_range(0, 19)]);
      2, 3: r = i_type(OPS[$urandom_range(0, 15)], r[25:21], r[20:16], r[15:0]);
      4:    r = i_type(6'b000001, r[25:21], ($urandom_range(0, 2) == 0) ? r[20:16]
                       : 5'($urandom_range(16, 17)), r[15:0]);
      default: r = r;
    endcase
    return r;
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [1:0]  alo;
    logic [31:0] exp;
  } load_case_t;

  initial begin
    load_case_t lc [6];
    logic [31:0] held_ret;
    lc[0] = '{6'b100000, 2'd3, 32'hFFFFFF80};
    lc[1] = '{6'b100100, 2'd3, 32'h00000080};
    lc[2] = '{6'b100000, 2'd0, 32'h00000001};
    lc[3] = '{6'b100001, 2'd2, 32'hFFFF80FF};
    lc[4] = '{6'b100101, 2'd0, 32'h00007F01};
    lc[5] = '{6'b100011, 2'd1, 32'h80FF7F01};

    reset = 1'b1; en = 1'b0; flush = 1'b0;
    instr_M = '0; pc_M = '0; alu_M = '0; mem_M = '0; alo_M = '0; hi_M = '0; lo_M = '0;
    clearModel();
    model_retired = 0;
    #12;
    $display("[TB] reset state");
    checkOutput();
    reset = 1'b0;

    $display("[TB] load extension");
    foreach (lc[i]) begin
      applyStimulus(i_type(lc[i].op, 5'd2, 5'd5, 16'h0010), 32'h100 + 32'(i * 4), $urandom,
                    32'h80FF7F01, lc[i].alo, $urandom, $urandom, 1'b1, 1'b0);
      checkOutput();
      checkValue("load_wdata", a_wdata, lc[i].exp);
      checkValue("load_waddr", {27'd0, a_waddr}, 32'd5);
      checkValue("load_we", {31'd0, a_we}, 32'd1);
    end

    $display("[TB] link writes");
    applyStimulus({6'b000011, 26'h0000040}, 32'h00003000, $urandom, $urandom, 2'd0,
                  $urandom, $urandom, 1'b1, 1'b0);
    checkOutput();
    checkValue("jal_waddr", {27'd0, a_waddr}, 32'd31);
    checkValue("jal_wdata", a_wdata, 32'h00003008);
    applyStimulus(i_type(6'b000001, 5'd4, 5'b10001, 16'h0004), 32'h00003000, $urandom,
                  $urandom, 2'd0, $urandom, $urandom, 1'b1, 1'b0);
    checkOutput();
    checkValue("bgezal_waddr", {27'd0, a_waddr}, 32'd31);
    checkValue("bgezal_wdata", a_wdata, 32'h00003008);
    applyStimulus(r_type(5'd9, 5'd0, 5'd7, 6'b001001), 32'h00003000, $urandom, $urandom,
                  2'd0, $urandom, $urandom, 1'b1, 1'b0);
    checkOutput();
    checkValue("jalr_waddr", {27'd0, a_waddr}, 32'd7);
    checkValue("jalr_wdata", a_wdata, 32'h00003008);

    $display("[TB] suppression");
    applyStimulus(r_type(5'd1, 5'd2, 5'd0, 6'b100001), 32'h40, 32'h55, 0, 0, 0, 0, 1'b1, 1'b0);
    checkOutput();
    checkValue("addu_r0_we", {31'd0, a_we}, 32'd0);
    applyStimulus(r_type(5'd31, 5'd0, 5'd0, 6'b001000), 32'h44, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    checkOutput();
    checkValue("jr_we", {31'd0, a_we}, 32'd0);
    applyStimulus(r_type(5'd3, 5'd4, 5'd6, 6'b011000), 32'h48, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    checkOutput();
    checkValue("mult_we", {31'd0, a_we}, 32'd0);
    applyStimulus(i_type(6'b101011, 5'd29, 5'd8, 16'h0004), 32'h4C, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    checkOutput();
    checkValue("sw_we", {31'd0, a_we}, 32'd0);
    applyStimulus(r_type(5'd0, 5'd0, 5'd3, 6'b010000), 32'h50, 32'hDEAD, 0, 0,
                  32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0);
    checkOutput();
    checkValue("mfhi_wdata", a_wdata, 32'h12345678);
    checkValue("mfhi_we", {31'd0, a_we}, 32'd1);
    checkValue("mfhi_nohilo_we", {31'd0, b_we}, 32'd0);

    $display("[TB] stall and flush");
    applyStimulus(r_type(5'd1, 5'd2, 5'd4, 6'b100001), 32'h60, 32'h777, 0, 0, 0, 0, 1'b1, 1'b0);
    checkOutput();
    held_ret = a_retired;
    for (int k = 0; k < 3; k++) begin
      applyStimulus($urandom, $urandom, $urandom, $urandom, 2'($urandom), $urandom,
                    $urandom, 1'b0, 1'b0);
      checkOutput();
      checkValue("stall_retired", a_retired, held_ret);
      checkValue("stall_wdata", a_wdata, 32'h777);
    end
    applyStimulus($urandom, $urandom, $urandom, $urandom, 2'd0, 0, 0, 1'b0, 1'b1);
    checkOutput();
    checkValue("flush_valid", {31'd0, a_valid}, 32'd0);
    checkValue("flush_retired", a_retired, held_ret + 32'd1);

    $display("[TB] reset mid-stream");
    applyStimulus(r_type(5'd1, 5'd2, 5'd9, 6'b100001), 32'h70, 32'h5, 0, 0, 0, 0, 1'b1, 1'b0);
    checkOutput();
    #3;
    reset = 1'b1;
    #1;
    clearModel();
    model_retired = 0;
    checkValue("rst_valid", {31'd0, a_valid}, 32'd0);
    checkValue("rst_we", {31'd0, a_we}, 32'd0);
    checkValue("rst_retired", a_retired, 32'd0);
    checkValue("rst_instr", a_instr, 32'd0);
    checkOutput();
    #1;
    reset = 1'b0;

    $display("[TB] counter wrap");
    for (int k = 1; k <= 18; k++) begin
      applyStimulus(r_type(5'd1, 5'd2, 5'd10, 6'b100001), 32'h1000 + 32'(4 * k), 32'(k),
                    0, 0, 0, 0, 1'b1, 1'b0);
      checkOutput();
      if (k == 17) checkValue("wrap_zero", {28'd0, b_retired}, 32'd0);
      if (k == 18) checkValue("wrap_one", {28'd0, b_retired}, 32'd1);
    end

    $display("[TB] random traffic");
    for (int k = 0; k < 400; k++) begin
      applyStimulus(randInstr(), $urandom, $urandom, $urandom, 2'($urandom), $urandom,
                    $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
      checkOutput();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
